// File: rtl/hex_level_decoder.sv
// Decodes a 7-segment "dash" display into a debounced logic level with edge strobes.
// A pattern is accepted once it has been seen on STABLE_CNT consecutive qualified samples.
module hex_level_decoder #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             sample_en,
  input  logic [6:0]       Seg_in,
  input  logic             clr_count,
  output logic             level,
  output logic             level_valid,
  output logic             fault,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count
);

  typedef enum logic [1:0] {CLS_LOW, CLS_HIGH, CLS_BAD} cls_t;
  typedef enum logic [1:0] {ST_UNKNOWN, ST_LOW, ST_HIGH, ST_FAULT} state_t;

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CNT);

  function automatic cls_t classify(input logic [6:0] seg);
    case (seg)
      7'b1110111: classify = CLS_LOW;
      7'b1111110: classify = CLS_HIGH;
      default:    classify = CLS_BAD;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] run);
    sat_inc = (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
  endfunction

  function automatic state_t cls_to_state(input cls_t c);
    case (c)
      CLS_LOW:  cls_to_state = ST_LOW;
      CLS_HIGH: cls_to_state = ST_HIGH;
      default:  cls_to_state = ST_FAULT;
    endcase
  endfunction

  cls_t             cls;
  cls_t             cand_q, cand_d;
  logic [3:0]       run_q, run_d;
  state_t           state_q, state_d;
  logic             accept;
  logic             level_q, level_d;
  logic             level_valid_q, level_valid_d;
  logic             fault_q, fault_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cls     = classify(Seg_in);
    cand_d  = cand_q;
    run_d   = run_q;
    state_d = state_q;
    accept  = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (sample_en) begin
      if (cls == cand_q) begin
        run_d = sat_inc(run_q);
      end else begin
        cand_d = cls;
        run_d  = 4'd1;
      end
      // Accept only on the sample that newly reaches saturation, not while it stays saturated.
      accept = (run_d == RUN_MAX) && !((cls == cand_q) && (run_q == RUN_MAX));
      if (accept) begin
        state_d = cls_to_state(cls);
        rise_d  = (state_q == ST_LOW)  && (state_d == ST_HIGH);
        fall_d  = (state_q == ST_HIGH) && (state_d == ST_LOW);
      end
    end

    if (clr_count) begin
      cnt_d = '0;
    end else if (rise_d || fall_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    level_d       = (state_d == ST_HIGH);
    level_valid_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
    fault_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cand_q        <= CLS_BAD;
      run_q         <= 4'd0;
      state_q       <= ST_UNKNOWN;
      level_q       <= 1'b0;
      level_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      cand_q        <= cand_d;
      run_q         <= run_d;
      state_q       <= state_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      fault_q       <= fault_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      cnt_q         <= cnt_d;
    end
  end

  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign fault       = fault_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign edge_count  = cnt_q;

endmodule

// File: tb/tb_hex_level_decoder.sv
// Scoreboard bench for hex_level_decoder: the driver queues the expected outputs for
// each clock it drives, and an independent monitor pops and compares after every edge.
module tb_hex_level_decoder;

  localparam logic [6:0] SEG_LOW  = 7'b1110111;
  localparam logic [6:0] SEG_HIGH = 7'b1111110;
  localparam logic [6:0] SEG_BAD  = 7'b0000000;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       sample_en;
  logic [6:0] Seg_in;
  logic       clr_count;
  logic       level, level_valid, fault, rise_pulse, fall_pulse;
  logic [7:0] edge_count;

  always #5 clk = ~clk;

  hex_level_decoder #(.STABLE_CNT(4), .CNT_W(8)) dut (
    .Clk(clk),
    .Reset_n(Reset_n),
    .sample_en(sample_en),
    .Seg_in(Seg_in),
    .clr_count(clr_count),
    .level(level),
    .level_valid(level_valid),
    .fault(fault),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .edge_count(edge_count)
  );

  // {level, level_valid, fault, rise, fall, edge_count[7:0]}
  logic [12:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [12:0] m_exp, m_act;

  logic       e_level, e_valid, e_fault;
  logic [7:0] e_cnt;

  task automatic set_exp(input logic l, input logic v, input logic f, input logic [7:0] c);
    e_level = l;
    e_valid = v;
    e_fault = f;
    e_cnt   = c;
  endtask

  task automatic drive(input logic rn, input logic en, input logic [6:0] seg,
                       input logic clr, input logic rise, input logic fall);
    @(negedge clk);
    Reset_n   = rn;
    sample_en = en;
    Seg_in    = seg;
    clr_count = clr;
    exp_q.push_back({e_level, e_valid, e_fault, rise, fall, e_cnt});
  endtask

  task automatic hold(input int n, input logic en, input logic [6:0] seg);
    for (int k = 0; k < n; k++) drive(1'b1, en, seg, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset with sample_en/clr_count active to show they are ignored.
  task automatic do_reset(input int n);
    set_exp(1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, SEG_LOW, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        m_act = {level, level_valid, fault, rise_pulse, fall_pulse, edge_count};
        total++;
        if (m_act !== m_exp) begin
          bad++;
          $display("FAIL step%0d {lvl,vld,flt,rise,fall,cnt} got=%h want=%h", total, m_act, m_exp);
        end
      end
    end
  end

  initial begin
    logic [6:0] seg;
    bit         to_low;
    int         guard;
    Reset_n   = 1'b0;
    sample_en = 1'b0;
    Seg_in    = SEG_BAD;
    clr_count = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 8'd0);

    do_reset(2);

    // Bottom dash accepted one clock after the 4th sample, no pulse.
    hold(3, 1'b1, SEG_LOW);
    set_exp(1'b0, 1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, SEG_LOW, 1'b0, 1'b0, 1'b0);
    hold(1, 1'b0, SEG_HIGH);

    // LOW -> HIGH: rise pulse once, then held with no repeat.
    hold(3, 1'b1, SEG_HIGH);
    set_exp(1'b1, 1'b1, 1'b0, 8'd1);
    drive(1'b1, 1'b1, SEG_HIGH, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b1, SEG_HIGH);

    // Glitch mid-run restarts it; sample_en gaps do not.
    hold(1, 1'b1, SEG_LOW);
    hold(1, 1'b0, SEG_BAD);
    hold(1, 1'b1, SEG_LOW);
    hold(2, 1'b0, SEG_LOW);
    hold(1, 1'b1, SEG_LOW);
    hold(1, 1'b1, SEG_HIGH);
    hold(1, 1'b1, SEG_LOW);
    hold(1, 1'b0, SEG_HIGH);
    hold(2, 1'b1, SEG_LOW);
    set_exp(1'b0, 1'b1, 1'b0, 8'd2);
    drive(1'b1, 1'b1, SEG_LOW, 1'b0, 1'b0, 1'b1);
    hold(2, 1'b1, SEG_LOW);

    // Unknown pattern -> FAULT; leaving FAULT gives no pulse.
    hold(3, 1'b1, SEG_BAD);
    set_exp(1'b0, 1'b0, 1'b1, 8'd2);
    drive(1'b1, 1'b1, SEG_BAD, 1'b0, 1'b0, 1'b0);
    hold(3, 1'b1, SEG_HIGH);
    set_exp(1'b1, 1'b1, 1'b0, 8'd2);
    drive(1'b1, 1'b1, SEG_HIGH, 1'b0, 1'b0, 1'b0);

    // Toggle up to edge_count = 8'hFF, then wrap.
    for (int i = 1; i <= 253; i++) begin
      to_low = (i % 2) == 1;
      seg    = to_low ? SEG_LOW : SEG_HIGH;
      hold(3, 1'b1, seg);
      set_exp(!to_low, 1'b1, 1'b0, 8'(2 + i));
      drive(1'b1, 1'b1, seg, 1'b0, !to_low, to_low);
    end
    hold(3, 1'b1, SEG_HIGH);
    set_exp(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, SEG_HIGH, 1'b0, 1'b1, 1'b0);

    hold(3, 1'b1, SEG_LOW);
    set_exp(1'b0, 1'b1, 1'b0, 8'd1);
    drive(1'b1, 1'b1, SEG_LOW, 1'b0, 1'b0, 1'b1);
    hold(3, 1'b1, SEG_HIGH);
    set_exp(1'b1, 1'b1, 1'b0, 8'd2);
    drive(1'b1, 1'b1, SEG_HIGH, 1'b0, 1'b1, 1'b0);
    // Clear coincident with an edge: count cleared, pulse still emitted.
    hold(3, 1'b1, SEG_LOW);
    set_exp(1'b0, 1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, SEG_LOW, 1'b1, 1'b0, 1'b1);

    // Reset after 3 of 4 samples aborts the run.
    hold(3, 1'b1, SEG_HIGH);
    do_reset(1);
    hold(1, 1'b1, SEG_HIGH);
    hold(2, 1'b1, SEG_HIGH);
    set_exp(1'b1, 1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, SEG_HIGH, 1'b0, 1'b0, 1'b0);
    hold(1, 1'b0, SEG_BAD);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
